// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the registered N-to-1 mux
// Purpose: channel-count limits and the flattened-channel slice index helper.
package mux_pkg;

    localparam int MUX_N_MAX = 16;
    localparam int MUX_N_MIN = 2;

    // Low bit of channel idx inside a flattened {ch[N-1], ..., ch[0]} bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - 2-entry valid/ready buffer with synchronous flush
// Purpose: registered output stage; a main register drives the output and a
//          skid register absorbs the single word accepted while the consumer stalls.
// Ports:   clk, rst (async, active-high), flush (sync discard)
//          in_data/in_valid/in_ready   upstream handshake
//          out_data/out_valid/out_ready downstream handshake
module skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             main_free;

    // Readiness looks only at registered state, flush and reset, so the
    // consumer's out_ready never forms a combinational path to the producer.
    assign in_ready  = !skid_valid && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    assign out_data  = main_data;
    assign out_valid = main_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            // Data registers keep their value; only the valid bits are dropped.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // Older skid word goes first; in_ready was low so no accept.
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// rtl/muxn_pipe.sv - N-to-1 multiplexer with registered elastic output
// Purpose: selects one of N valid/ready channels per cycle and presents the
//          accepted word one cycle later behind a 2-entry skid buffer.
// Ports:   clk, rst (async, active-high)
//          sel                  binary channel select
//          in/in_valid/in_ready flattened channel data and per-channel handshake
//          out/out_valid/out_ready registered output handshake
//          flush                discard buffered words and clear sel_err
//          sel_err              sticky: an out-of-range select was seen
module muxn_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               flush,
    output logic               sel_err
);

    generate
        if ((N < MUX_N_MIN) || (N > MUX_N_MAX)) begin : g_bad_n
            $error("muxn_pipe: N must lie within 2..16");
        end
    endgenerate

    logic             sel_ok;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             buf_ready;

    // Decode by explicit compare so unselected channels (possibly X) never
    // reach the buffer, and a select >= N simply matches nothing.
    always_comb begin
        sel_ok    = 1'b0;
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ok    = 1'b1;
                sel_valid = in_valid[i];
                sel_data  = in[slice_lo(i, WIDTH) +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                in_ready[i] = buf_ready;
            end
        end
    end

    // Flush takes priority over a simultaneous illegal select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (flush) begin
            sel_err <= 1'b0;
        end else if (!sel_ok) begin
            sel_err <= 1'b1;
        end
    end

    skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_data  (sel_data),
        .in_valid (sel_valid && sel_ok),
        .in_ready (buf_ready),
        .out_data (out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule

// File: tb/tb_muxn_pipe.sv
// tb/tb_muxn_pipe.sv - self-checking bench for muxn_pipe
module tb_muxn_pipe;

    logic         clk = 1'b0;
    logic         rst;

    logic [1:0]   sel4;
    logic [127:0] in4;
    logic [3:0]   iv4;
    logic [3:0]   ir4;
    logic [31:0]  out4;
    logic         ov4;
    logic         or4;
    logic         fl4;
    logic         se4;

    logic [1:0]   sel3;
    logic [95:0]  in3;
    logic [2:0]   iv3;
    logic [2:0]   ir3;
    logic [31:0]  out3;
    logic         ov3;
    logic         or3;
    logic         fl3;
    logic         se3;

    int tests = 0;
    int fails = 0;
    logic [31:0] sbq[$];

    always #5 clk = ~clk;

    muxn_pipe #(.WIDTH(32), .N(4)) dut4 (
        .clk(clk), .rst(rst), .sel(sel4), .in(in4), .in_valid(iv4), .in_ready(ir4),
        .out(out4), .out_valid(ov4), .out_ready(or4), .flush(fl4), .sel_err(se4)
    );

    muxn_pipe #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .in(in3), .in_valid(iv3), .in_ready(ir3),
        .out(out3), .out_valid(ov3), .out_ready(or3), .flush(fl3), .sel_err(se3)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] iv;
        logic       fl;
        logic [3:0] exp_ir;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && !fl4 && ov4 && or4) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_word", out4, 32'hxxxx_xxxx);
            end else begin
                check("sb_out", out4, sbq.pop_front());
            end
        end
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{sel: 2'd0, iv: 4'b1111, fl: 1'b0, exp_ir: 4'b0001};
        vecs[1] = '{sel: 2'd1, iv: 4'b0000, fl: 1'b0, exp_ir: 4'b0010};
        vecs[2] = '{sel: 2'd3, iv: 4'b1000, fl: 1'b0, exp_ir: 4'b1000};
        vecs[3] = '{sel: 2'd2, iv: 4'b1011, fl: 1'b0, exp_ir: 4'b0100};
        vecs[4] = '{sel: 2'd1, iv: 4'b0010, fl: 1'b1, exp_ir: 4'b0000};
        vecs[5] = '{sel: 2'd3, iv: 4'b1111, fl: 1'b1, exp_ir: 4'b0000};

        rst = 1'b1;
        sel4 = 2'd2; in4 = '0; iv4 = 4'b0100; or4 = 1'b0; fl4 = 1'b0;
        sel3 = 2'd0; in3 = '0; iv3 = '0;     or3 = 1'b1; fl3 = 1'b0;
        tick; tick;
        check("rst_ov", {31'd0, ov4}, 32'd0);
        check("rst_out", out4, 32'd0);
        check("rst_sel_err", {31'd0, se4}, 32'd0);
        check("rst_in_ready", {28'd0, ir4}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {28'd0, ir4}, 32'h4);
        iv4 = '0;
        or4 = 1'b1;
        tick;

        // Readiness table, buffer empty; valid is withdrawn before the edge.
        for (int k = 0; k < 6; k++) begin
            sel4 = vecs[k].sel; iv4 = vecs[k].iv; fl4 = vecs[k].fl;
            #1;
            check($sformatf("tbl_in_ready_%0d", k), {28'd0, ir4}, {28'd0, vecs[k].exp_ir});
            iv4 = '0;
            tick;
            fl4 = 1'b0;
        end

        // Streaming on channel 1, no bubbles.
        sel4 = 2'd1; or4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in4[32 +: 32] = 32'hA0 + 32'(k); iv4 = 4'b0010;
            sbq.push_back(32'hA0 + 32'(k));
            #1;
            check($sformatf("stream_ready_%0d", k), {28'd0, ir4}, 32'h2);
            tick;
            check($sformatf("stream_ov_%0d", k), {31'd0, ov4}, 32'd1);
            check($sformatf("stream_out_%0d", k), out4, 32'hA0 + 32'(k));
        end
        iv4 = '0;
        tick;
        check("stream_idle_ov", {31'd0, ov4}, 32'd0);

        // Back-pressure: skid fills, third word held by the source.
        or4 = 1'b0;
        in4[32 +: 32] = 32'hB0; iv4 = 4'b0010; sbq.push_back(32'hB0);
        tick;
        in4[32 +: 32] = 32'hB1; sbq.push_back(32'hB1);
        #1;
        check("bp_ready_skid_empty", {28'd0, ir4}, 32'h2);
        tick;
        in4[32 +: 32] = 32'hB2;
        #1;
        check("bp_ready_skid_full", {28'd0, ir4}, 32'h0);
        check("bp_out_b0", out4, 32'hB0);
        tick;
        check("bp_out_stable", out4, 32'hB0);
        or4 = 1'b1;
        #1;
        check("bp_ready_ignores_out_ready", {28'd0, ir4}, 32'h0);
        tick;
        check("bp_out_b1", out4, 32'hB1);
        sbq.push_back(32'hB2);
        #1;
        check("bp_ready_reopen", {28'd0, ir4}, 32'h2);
        tick;
        iv4 = '0;
        check("bp_out_b2", out4, 32'hB2);
        tick;
        check("bp_idle_ov", {31'd0, ov4}, 32'd0);

        // Select switch with channel 1 valid throughout.
        in4[32 +: 32] = 32'hDEAD;
        sel4 = 2'd0; in4[0 +: 32] = 32'h11; iv4 = 4'b0011; sbq.push_back(32'h11);
        #1;
        check("sw_ready_ch0", {28'd0, ir4}, 32'h1);
        tick;
        check("sw_out_11", out4, 32'h11);
        sel4 = 2'd3; in4[96 +: 32] = 32'h33; iv4 = 4'b1010; sbq.push_back(32'h33);
        #1;
        check("sw_ready_ch3", {28'd0, ir4}, 32'h8);
        tick;
        check("sw_out_33", out4, 32'h33);
        iv4 = 4'b0010;
        sel4 = 2'd0;
        tick;
        iv4 = '0;
        check("sw_idle_ov", {31'd0, ov4}, 32'd0);

        // Flush with main and skid both full; neither word may appear later.
        or4 = 1'b0; sel4 = 2'd0;
        in4[0 +: 32] = 32'hC0; iv4 = 4'b0001;
        tick;
        in4[0 +: 32] = 32'hC1;
        tick;
        iv4 = 4'b0001; in4[0 +: 32] = 32'hC2;
        fl4 = 1'b1; or4 = 1'b1;
        iv4 = '0;
        #1;
        check("flush_in_ready", {28'd0, ir4}, 32'h0);
        tick;
        fl4 = 1'b0;
        check("flush_ov", {31'd0, ov4}, 32'd0);
        tick; tick;
        check("flush_stays_empty", {31'd0, ov4}, 32'd0);

        // Illegal select on the 3-channel instance; flush wins over a new error.
        sel3 = 2'd3; iv3 = 3'b111;
        #1;
        check("ill_in_ready", {29'd0, ir3}, 32'h0);
        tick;
        check("ill_sel_err_set", {31'd0, se3}, 32'd1);
        check("ill_nothing_accepted", {31'd0, ov3}, 32'd0);
        sel3 = 2'd0; iv3 = '0;
        #1;
        check("ill_ready_legal", {29'd0, ir3}, 32'h1);
        tick;
        check("ill_sel_err_sticky", {31'd0, se3}, 32'd1);
        sel3 = 2'd3; fl3 = 1'b1;
        tick;
        check("ill_flush_clears", {31'd0, se3}, 32'd0);
        fl3 = 1'b0; sel3 = 2'd0;
        tick;
        check("ill_stays_clear", {31'd0, se3}, 32'd0);

        // Reset mid-stream with both entries full.
        or4 = 1'b0; sel4 = 2'd0;
        in4[0 +: 32] = 32'hD0; iv4 = 4'b0001;
        tick;
        in4[0 +: 32] = 32'hD1;
        tick;
        iv4 = '0;
        check("mid_pre_ov", {31'd0, ov4}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ov", {31'd0, ov4}, 32'd0);
        check("mid_rst_out", out4, 32'd0);
        check("mid_rst_sel_err", {31'd0, se4}, 32'd0);
        sel4 = 2'd2; iv4 = 4'b0100;
        #1;
        check("mid_rst_in_ready", {28'd0, ir4}, 32'h0);
        tick;
        rst = 1'b0;
        #1;
        check("mid_post_in_ready", {28'd0, ir4}, 32'h4);
        iv4 = '0; or4 = 1'b1;
        tick; tick;
        check("mid_post_ov", {31'd0, ov4}, 32'd0);

        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
Parametrised N-to-1 multiplexer with a registered, elastic output stage. One input channel, chosen by SEL, is accepted per cycle through a valid/ready handshake. Accepted data is presented one cycle later behind a 2-entry skid buffer, so back-pressure never drops or duplicates a word. It is used wherever pipeline stages merge multiple sources (PC sources, writeback sources, forwarding paths) and a registered, stallable, flushable select is needed.

Parameters:
WIDTH, 32, data width of each channel and of OUT
N, 4, number of input channels; legal range 2..16
SEL_W, $clog2(N), select width; localparam, not overridable

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
SEL  in  SEL_W  binary channel select; sampled every cycle
IN  in  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
IN_VALID  in  N  per-channel valid
IN_READY  out  N  per-channel ready; at most one bit set
OUT  out  WIDTH  registered output data
OUT_VALID  out  1  OUT holds a valid word
OUT_READY  in  1  consumer accepts OUT this cycle
FLUSH  in  1  synchronous discard of all buffered words
SEL_ERR  out  1  sticky flag: SEL >= N was seen

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous and active-high.
- Reset (async assert, synchronous release at CLK): OUT_VALID=0, OUT=0, SEL_ERR=0, skid entry empty, IN_READY=0 while RST is high.
- Storage: main register (drives OUT/OUT_VALID) plus one skid register.
- Readiness: IN_READY[i] = (i==SEL) && (SEL<N) && !skid_valid && !FLUSH. This is combinational from SEL, FLUSH and registered state only; it never depends on OUT_READY.
- Accept: accept = IN_VALID[SEL] && IN_READY[SEL]. Unselected channels are never accepted, whatever their valid.
- Drain: drain = OUT_VALID && OUT_READY.
- State update per edge, given no FLUSH:
  - main empty or draining, skid empty: accept loads main; otherwise main valid <= 0 if drained.
  - main empty or draining, skid full: skid moves to main, skid empties. A new accept is impossible here because ready is 0.
  - main full and not draining: accept loads skid (skid was empty).
- Latency is 1 cycle from accept to OUT_VALID. Sustained throughput is 1 word/cycle when OUT_READY=1.
- Ordering is strictly FIFO across both entries. OUT is stable while OUT_VALID=1 && OUT_READY=0.
- FLUSH=1: IN_READY all 0 that cycle. At the edge both valid bits clear and SEL_ERR clears. OUT data value may remain; only valid is cleared. FLUSH overrides a simultaneous drain.
- SEL>=N (only possible when N is not a power of 2): no channel ready, nothing accepted. SEL_ERR sets at the edge and holds until RST or FLUSH. When set and cleared in the same cycle, FLUSH wins.
- Data width: OUT is exactly WIDTH bits, with no sign/zero extension. An X on an unselected channel must not propagate.
- Reset mid-operation: all buffered words are lost immediately; OUT_VALID drops asynchronously.

Decomposition:
- Package mux_pkg: function for the flattened-channel slice index; constants MUX_N_MAX=16, MUX_N_MIN=2.
- Sub-module skid_buf (parameter WIDTH): 2-entry valid/ready buffer with flush. It owns both registers and the readiness logic.
- muxn_pipe does: the select decode, IN_READY fan-out, SEL range check and SEL_ERR.
- Elaboration assertion on N range.

Test Plan:
1. Reset: assert RST mid-stream with main and skid full -> OUT_VALID=0, OUT=0, SEL_ERR=0 in the same cycle; after release with SEL=2 and IN_VALID=4'b0100, IN_READY=4'b0100.
2. Streaming: N=4, SEL=1, ch1 sends 0xA0,0xA1,0xA2 on consecutive cycles, OUT_READY=1 -> OUT shows 0xA0,0xA1,0xA2 one cycle after each accept, with no bubbles.
3. Back-pressure: OUT_READY=0 after 0xB0 is accepted, send 0xB1 -> skid fills, IN_READY[SEL]=0, and 0xB2 is held by the source. Raise OUT_READY -> OUT gives 0xB0,0xB1,0xB2 in order, none lost or duplicated.
4. Select switch: SEL=0 sends 0x11, next cycle SEL=3 sends 0x33, ch1 valid throughout -> OUT=0x11 then 0x33; ch1 is never accepted.
5. Flush: main=0xC0 and skid=0xC1 with FLUSH=1 and OUT_READY=1 -> IN_READY=0 that cycle, OUT_VALID=0 next cycle, and neither word appears afterwards.
6. Illegal select: N=3, SEL=3, IN_VALID=3'b111 -> IN_READY=0 and SEL_ERR=1 after the edge, still 1 with SEL=0. FLUSH clears it to 0.
